// File: rtl/kanagawa_hal_pkg.sv
// Shared definitions for the kanagawa HAL ready/valid helpers:
// output-slot state encoding and the lane-counter width helper.
package kanagawa_hal_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } rv_slot_e;

    // Width of a counter that indexes RATIO lanes; never narrower than one bit.
    function automatic int lane_cnt_width(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/kanagawa_hal_rv_upsizer_if.sv
// Narrow-in / wide-out ready/valid bundle for the upsizer.
// slave: the upsizer's view; master: the environment driving beats and consuming words.
interface kanagawa_hal_rv_upsizer_if #(
    parameter int IN_WIDTH = 32,
    parameter int RATIO    = 4
);
    logic                      input_valid;
    logic                      input_ready;
    logic [IN_WIDTH-1:0]       input_data;
    logic                      input_last;
    logic                      output_valid;
    logic                      output_ready;
    logic [IN_WIDTH*RATIO-1:0] output_data;
    logic [RATIO-1:0]          output_keep;
    logic                      output_last;

    modport slave (
        input  input_valid, input_data, input_last, output_ready,
        output input_ready, output_valid, output_data, output_keep, output_last
    );

    modport master (
        output input_valid, input_data, input_last, output_ready,
        input  input_ready, output_valid, output_data, output_keep, output_last
    );
endinterface

// File: rtl/kanagawa_hal_rv_hold_reg.sv
// One-entry register slice: a load writes the entry, a drain of a full entry
// empties it; load has priority so drain+load replaces the word without a bubble.
// valid comes straight from the slot flop.
module kanagawa_hal_rv_hold_reg
    import kanagawa_hal_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    rv_slot_e slot;

    // Slot state and payload: load wins over drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= SLOT_EMPTY;
            data <= '0;
        end else if (load) begin
            slot <= SLOT_FULL;
            data <= load_data;
        end else if (drain && slot == SLOT_FULL) begin
            slot <= SLOT_EMPTY;
        end
    end

    assign valid = (slot == SLOT_FULL);
endmodule

// File: rtl/kanagawa_hal_rv_upsizer.sv
// Ready/valid width upsizer: packs RATIO narrow beats into one wide word.
// Lane 0 holds the first beat. input_ready is a flop, so there is no
// combinational path from output_ready to input_ready.
// Optional macro KANAGAWA_UPSIZER_ASSERT_EN compiles in simulation assertions.
module kanagawa_hal_rv_upsizer
    import kanagawa_hal_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int RATIO      = 4,
    parameter int LAST_FLUSH = 1
) (
    input logic                       clk,
    input logic                       rst,
    kanagawa_hal_rv_upsizer_if.slave  bus
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CNT_W     = lane_cnt_width(RATIO);
    localparam int WORD_W    = OUT_WIDTH + RATIO + 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]     acc_cnt;
    logic [OUT_WIDTH-1:0] acc_data;
    logic [RATIO-1:0]     acc_keep;
    logic                 acc_last;
    logic                 acc_done;
    logic                 in_ready;

    logic                 slot_free;
    logic                 beat_fire;
    logic                 beat_completes;
    logic                 hold_load;
    logic [OUT_WIDTH-1:0] merged_data;
    logic [RATIO-1:0]     merged_keep;
    logic [WORD_W-1:0]    load_word;
    logic [WORD_W-1:0]    held_word;
    logic                 held_valid;

    assign slot_free      = ~held_valid | bus.output_ready;
    assign beat_fire      = bus.input_valid & in_ready;
    assign beat_completes = beat_fire &
                            ((acc_cnt == LAST_LANE) | (bus.input_last & (LAST_FLUSH != 0)));

    // Accumulator contents with the incoming beat written into lane acc_cnt.
    always_comb begin
        merged_data = acc_data;
        merged_keep = acc_keep;
        for (int i = 0; i < RATIO; i++) begin
            if (acc_cnt == CNT_W'(i)) begin
                merged_data[i*IN_WIDTH +: IN_WIDTH] = bus.input_data;
                merged_keep[i]                      = 1'b1;
            end
        end
    end

    // A parked word takes precedence; input is stalled while one exists.
    assign hold_load = slot_free & (acc_done | beat_completes);
    assign load_word = acc_done ? {acc_last, acc_keep, acc_data}
                                : {bus.input_last, merged_keep, merged_data};

    // Accumulator, lane counter and park/unpark control; input_ready mirrors ~acc_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt  <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            acc_last <= 1'b0;
            acc_done <= 1'b0;
            in_ready <= 1'b1;
        end else if (acc_done) begin
            if (slot_free) begin
                acc_data <= '0;
                acc_keep <= '0;
                acc_last <= 1'b0;
                acc_done <= 1'b0;
                in_ready <= 1'b1;
            end
        end else if (beat_completes) begin
            acc_cnt <= '0;
            if (slot_free) begin
                acc_data <= '0;
                acc_keep <= '0;
                acc_last <= 1'b0;
            end else begin
                acc_data <= merged_data;
                acc_keep <= merged_keep;
                acc_last <= bus.input_last;
                acc_done <= 1'b1;
                in_ready <= 1'b0;
            end
        end else if (beat_fire) begin
            acc_cnt  <= acc_cnt + CNT_W'(1);
            acc_data <= merged_data;
            acc_keep <= merged_keep;
        end
    end

    kanagawa_hal_rv_hold_reg #(
        .WIDTH (WORD_W)
    ) u_out_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load),
        .load_data (load_word),
        .drain     (bus.output_ready),
        .valid     (held_valid),
        .data      (held_word)
    );

    assign bus.input_ready  = in_ready;
    assign bus.output_valid = held_valid;
    assign {bus.output_last, bus.output_keep, bus.output_data} = held_word;

`ifdef KANAGAWA_UPSIZER_ASSERT_EN
    a_input_held : assert property (@(posedge clk) disable iff (rst)
        bus.input_valid && !bus.input_ready |=>
            bus.input_valid && $stable(bus.input_data) && $stable(bus.input_last));

    a_output_stable : assert property (@(posedge clk) disable iff (rst)
        held_valid && !bus.output_ready |=> held_valid && $stable(held_word));

    a_park_only_when_full : assert property (@(posedge clk) disable iff (rst)
        acc_done |-> held_valid);
`else
    // Assertions excluded from this build; logic is unchanged.
`endif
endmodule

// File: tb/tb_kanagawa_hal_rv_upsizer.sv
// Self-checking bench for kanagawa_hal_rv_upsizer (IN_WIDTH=8, RATIO=4).
// dut_f (LAST_FLUSH=1) takes the directed scenarios; dut_n (LAST_FLUSH=0)
// takes randomized traffic scored against a beat-level packing model.
module tb_kanagawa_hal_rv_upsizer;
    localparam int W = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kanagawa_hal_rv_upsizer_if #(.IN_WIDTH(W), .RATIO(R)) bus_f ();
    kanagawa_hal_rv_upsizer_if #(.IN_WIDTH(W), .RATIO(R)) bus_n ();

    kanagawa_hal_rv_upsizer #(.IN_WIDTH(W), .RATIO(R), .LAST_FLUSH(1)) dut_f (
        .clk (clk), .rst (rst), .bus (bus_f));
    kanagawa_hal_rv_upsizer #(.IN_WIDTH(W), .RATIO(R), .LAST_FLUSH(0)) dut_n (
        .clk (clk), .rst (rst), .bus (bus_n));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t f_words[$];
    int    f_beats      = 0;
    bit    watch_ready  = 1'b0;
    bit    f_ready_drop = 1'b0;

    // Observe bus_f handshakes midway between edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_f.output_valid && bus_f.output_ready)
                f_words.push_back('{data: bus_f.output_data, keep: bus_f.output_keep,
                                    last: bus_f.output_last});
            if (bus_f.input_valid && bus_f.input_ready) f_beats++;
            if (watch_ready && !bus_f.input_ready) f_ready_drop = 1'b1;
        end
    end

    // Reference packer for bus_n: every accepted beat is appended to the
    // current group; four beats make a word, last is the fourth beat's flag.
    logic [7:0]  cur_beats[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_keep[$];
    logic        exp_last[$];
    int          n_words = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_n.output_valid && bus_n.output_ready) begin
                check_eq("rand_word_expected", 64'(exp_data.size() > 0), 64'd1);
                if (exp_data.size() > 0) begin
                    check_eq("rand_data", bus_n.output_data, exp_data.pop_front());
                    check_eq("rand_keep", bus_n.output_keep, exp_keep.pop_front());
                    check_eq("rand_last", bus_n.output_last, exp_last.pop_front());
                end
                n_words++;
            end
            if (bus_n.input_valid && bus_n.input_ready) begin
                cur_beats.push_back(bus_n.input_data);
                if (cur_beats.size() == R) begin
                    logic [31:0] d;
                    d = '0;
                    for (int i = 0; i < R; i++) d = d | (32'(cur_beats[i]) << (8 * i));
                    exp_data.push_back(d);
                    exp_keep.push_back(4'hF);
                    exp_last.push_back(bus_n.input_last);
                    cur_beats.delete();
                end
            end
        end
    end

    // Offer one beat and return one cycle after it is accepted (bounded wait).
    task automatic send(input bit on_n, input logic [7:0] d, input logic l);
        int n;
        n = 0;
        if (on_n) begin
            bus_n.input_valid = 1'b1; bus_n.input_data = d; bus_n.input_last = l;
        end else begin
            bus_f.input_valid = 1'b1; bus_f.input_data = d; bus_f.input_last = l;
        end
        while (!(on_n ? bus_n.input_ready : bus_f.input_ready) && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 64) check_eq("send_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        if (on_n) bus_n.input_valid = 1'b0;
        else      bus_f.input_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        time t1;
        bit  n_done;
        n_done = 1'b0;
        bus_f.input_valid = 0; bus_f.input_data = 0; bus_f.input_last = 0; bus_f.output_ready = 1;
        bus_n.input_valid = 0; bus_n.input_data = 0; bus_n.input_last = 0; bus_n.output_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_eq("rst_out_valid", bus_f.output_valid, 0);
        check_eq("rst_out_data",  bus_f.output_data, 0);
        check_eq("rst_out_keep",  bus_f.output_keep, 0);
        check_eq("rst_out_last",  bus_f.output_last, 0);
        check_eq("rst_in_ready",  bus_f.input_ready, 1);

        // Full word, one-cycle latency
        send(0, 8'h01, 0); send(0, 8'h02, 0); send(0, 8'h03, 0);
        check_eq("t1_valid_early", bus_f.output_valid, 0);
        send(0, 8'h04, 0);
        check_eq("t1_valid", bus_f.output_valid, 1);
        check_eq("t1_data",  bus_f.output_data, 32'h04030201);
        check_eq("t1_keep",  bus_f.output_keep, 4'hF);
        check_eq("t1_last",  bus_f.output_last, 0);

        // Early flush on input_last, then lane 0 restart
        send(0, 8'h11, 0); send(0, 8'h22, 1);
        check_eq("t2_valid", bus_f.output_valid, 1);
        check_eq("t2_data",  bus_f.output_data, 32'h00002211);
        check_eq("t2_keep",  bus_f.output_keep, 4'h3);
        check_eq("t2_last",  bus_f.output_last, 1);
        send(0, 8'h33, 0); send(0, 8'h44, 0); send(0, 8'h55, 0); send(0, 8'h66, 0);
        check_eq("t2_next_data", bus_f.output_data, 32'h66554433);
        check_eq("t2_next_keep", bus_f.output_keep, 4'hF);

        // Back-pressure: one held plus one parked word, then release in order
        @(posedge clk); #1;
        f_words.delete();
        f_beats = 0;
        bus_f.output_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) send(0, 8'(8'h80 + i), 0);
            end
            begin
                repeat (14) @(posedge clk);
                #1;
                check_eq("t3_accepted", f_beats, 8);
                check_eq("t3_in_ready", bus_f.input_ready, 0);
                check_eq("t3_held_data", bus_f.output_data, 32'h83828180);
                bus_f.output_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check_eq("t3_word_count", f_words.size(), 3);
        for (int i = 0; i < 3 && i < f_words.size(); i++) begin
            logic [31:0] e;
            e = {8'(8'h83 + 4*i), 8'(8'h82 + 4*i), 8'(8'h81 + 4*i), 8'(8'h80 + 4*i)};
            check_eq("t3_word_data", f_words[i].data, e);
        end

        // Sustained throughput
        f_words.delete();
        f_ready_drop = 1'b0;
        watch_ready  = 1'b1;
        t0 = $time;
        for (int i = 0; i < 400; i++) send(0, 8'(i), 0);
        t1 = $time;
        watch_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t4_cycles", 64'((t1 - t0) / 10), 400);
        check_eq("t4_ready_drop", f_ready_drop, 0);
        check_eq("t4_word_count", f_words.size(), 100);
        for (int i = 0; i < f_words.size() && i < 100; i++) begin
            logic [31:0] e;
            e = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
            check_eq("t4_word_data", f_words[i].data, e);
        end

        // Reset mid-word
        f_words.delete();
        send(0, 8'hA1, 0); send(0, 8'hA2, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t5_out_valid", bus_f.output_valid, 0);
        check_eq("t5_in_ready",  bus_f.input_ready, 1);
        send(0, 8'hB1, 0); send(0, 8'hB2, 0); send(0, 8'hB3, 0); send(0, 8'hB4, 0);
        check_eq("t5_data", bus_f.output_data, 32'hB4B3B2B1);
        check_eq("t5_keep", bus_f.output_keep, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        check_eq("t5_word_count", f_words.size(), 1);

        // Randomized traffic on the LAST_FLUSH=0 instance
        fork
            begin
                while (!n_done) begin
                    @(posedge clk); #1;
                    bus_n.output_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 600; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(1, 8'($urandom), ($urandom_range(0, 5) == 0));
                end
                n_done = 1'b1;
            end
        join
        bus_n.output_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("rand_word_count", n_words, 150);
        check_eq("rand_pending",    exp_data.size(), 0);
        check_eq("rand_partial",    cur_beats.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
